// File: rtl/sum_ctrl_pkg.sv
// sum_ctrl_pkg: shared state encoding and default sizing for the sum frame datapath
package sum_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, CLEAR, STREAM, WAIT_SUM, HOLD} state_t;
  localparam int SUM_W_DEF = 17;
  localparam int FRAME_LEN_DEF = 256;
  localparam int TIMEOUT_DEF = 64;
endpackage

// File: rtl/sum_ctrl_timeout.sv
// sum_ctrl_timeout: loadable down-counter whose expire flags the last enabled cycle before it runs out
module sum_ctrl_timeout #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] value,
  output logic [W-1:0] count,
  output logic         expire
);
  always_ff @(posedge clk) begin
    if (rst) count <= '0;
    else if (load) count <= value;
    else if (en && count != '0) count <= count - W'(1);
  end
  assign expire = en && count == W'(1);
endmodule

// File: rtl/sum_frame_controller.sv
// sum_frame_controller: frames FRAME_LEN counter samples into the summer and holds the captured sum
module sum_frame_controller
  import sum_ctrl_pkg::*;
#(
  parameter int SUM_W     = SUM_W_DEF,
  parameter int FRAME_LEN = FRAME_LEN_DEF,
  parameter int TIMEOUT   = TIMEOUT_DEF
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic             abort,
  output logic             cnt_clr,
  output logic             cnt_en,
  output logic             data_start,
  input  logic [SUM_W-1:0] sum,
  input  logic             sum_enable,
  output logic [SUM_W-1:0] result,
  output logic             result_valid,
  input  logic             result_ready,
  output logic             busy,
  output logic             timeout_err
);
  localparam int IW = $clog2(FRAME_LEN);
  localparam int TW = $clog2(TIMEOUT + 1);
  state_t state, state_n;
  logic [IW-1:0] idx;
  logic [TW-1:0] tmo;
  logic expire;
  sum_ctrl_timeout #(.W(TW)) u_tmo (
    .clk(CLK),
    .rst(RST),
    .load(state != WAIT_SUM),
    .en(state == WAIT_SUM),
    .value(TW'(TIMEOUT)),
    .count(tmo),
    .expire(expire)
  );
  always_comb begin
    state_n = state;
    if (abort && state != IDLE) state_n = IDLE;
    else if (state == IDLE) state_n = start ? CLEAR : IDLE;
    else if (state == CLEAR) state_n = STREAM;
    else if (state == STREAM) state_n = idx == IW'(FRAME_LEN - 1) ? WAIT_SUM : STREAM;
    else if (state == WAIT_SUM) state_n = sum_enable ? HOLD : expire ? IDLE : WAIT_SUM;
    else if (state == HOLD) state_n = result_ready ? IDLE : HOLD;
    else state_n = IDLE;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      idx <= '0;
      result <= '0;
      timeout_err <= 1'b0;
    end else begin
      state <= state_n;
      idx <= (state == STREAM && state_n == STREAM) ? idx + IW'(1) : '0;
      if (state == WAIT_SUM && sum_enable && !abort) result <= sum;
      if (state == IDLE && start) timeout_err <= 1'b0;
      else if (state == WAIT_SUM && expire && !sum_enable && !abort) timeout_err <= 1'b1;
    end
  end
  // the WAIT_SUM close marker is the cycle where the timeout counter is still full
  assign data_start   = (state == STREAM && idx == '0) || (state == WAIT_SUM && tmo == TW'(TIMEOUT));
  assign cnt_clr      = state == CLEAR;
  assign cnt_en       = state == STREAM;
  assign result_valid = state == HOLD;
  assign busy         = state != IDLE;
endmodule

// File: tb/tb_sum_frame_controller.sv
// tb_sum_frame_controller: scoreboard bench with a counter/summer model around the controller
module tb_sum_frame_controller;
  import sum_ctrl_pkg::*;
  localparam int SW = SUM_W_DEF;
  localparam int FL = 4;
  localparam int TO = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic result_ready = 1'b0;
  logic cnt_clr, cnt_en, data_start, sum_enable, result_valid, busy, timeout_err;
  logic [SW-1:0] sum, result, cnt, acc;
  logic [SW-1:0] q[$];
  int n_checks = 0;
  int n_fail = 0;
  int se_delay = 1;
  int wcnt;

  always #5 clk = ~clk;

  sum_frame_controller #(.SUM_W(SW), .FRAME_LEN(FL), .TIMEOUT(TO)) dut (
    .CLK(clk),
    .RST(rst),
    .start(start),
    .abort(abort),
    .cnt_clr(cnt_clr),
    .cnt_en(cnt_en),
    .data_start(data_start),
    .sum(sum),
    .sum_enable(sum_enable),
    .result(result),
    .result_valid(result_valid),
    .result_ready(result_ready),
    .busy(busy),
    .timeout_err(timeout_err)
  );

  // counter plus summer: restarts on the sample marker, strobes se_delay cycles after the close marker
  always @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      acc <= '0;
      wcnt <= 0;
    end else begin
      if (cnt_clr) cnt <= '0;
      else if (cnt_en) cnt <= cnt + 1'b1;
      if (cnt_en) acc <= data_start ? cnt : acc + cnt;
      if (data_start && !cnt_en) wcnt <= 1;
      else if (wcnt != 0) wcnt <= (!busy || sum_enable) ? 0 : wcnt + 1;
    end
  end
  assign sum = acc;
  assign sum_enable = se_delay > 0 && wcnt == se_delay;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 40 && !result_valid; i++) tick();
    chk("wait_valid", result_valid, 1);
  endtask

  task automatic wait_close();
    for (int i = 0; i < 20 && !(data_start && !cnt_en); i++) tick();
    chk("close_seen", data_start && !cnt_en, 1);
  endtask

  task automatic ack();
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    chk("ack_idle", busy, 0);
    chk("ack_valid_drop", result_valid, 0);
  endtask

  // monitor: every presented result must match the oldest expectation; handshake retires it
  always @(negedge clk) begin
    if (!rst && result_valid) begin
      if (q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_result: got %0d expected none", result);
      end else begin
        chk("result", result, q[0]);
        if (result_ready) void'(q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_outs", {cnt_clr, cnt_en, data_start, result_valid, timeout_err}, 0);
    chk("rst_result", result, 0);
    rst = 1'b0;
    tick();
    q.push_back(6);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("clr", cnt_clr, 1);
    chk("clr_busy", busy, 1);
    chk("clr_no_en", cnt_en, 0);
    tick();
    chk("ds_first", data_start, 1);
    chk("cnt_at_ds", cnt, 0);
    chk("en0", cnt_en, 1);
    for (int i = 1; i < FL; i++) begin
      tick();
      chk("en", cnt_en, 1);
      chk("ds_mid", data_start, 0);
    end
    tick();
    chk("close", data_start, 1);
    chk("close_en", cnt_en, 0);
    wait_valid();
    repeat (3) tick();
    chk("valid_held", result_valid, 1);
    ack();
    q.push_back(6);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_valid();
    for (int i = 0; i < 20; i++) begin
      start = (i % 3 == 0);
      tick();
    end
    start = 1'b0;
    chk("bp_valid", result_valid, 1);
    ack();
    repeat (3) tick();
    chk("no_queued_frame", busy, 0);
    q.push_back(6);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_valid();
    ack();
    se_delay = -1;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_close();
    repeat (TO - 1) tick();
    chk("tmo_not_yet", timeout_err, 0);
    chk("tmo_busy", busy, 1);
    tick();
    chk("tmo_err", timeout_err, 1);
    chk("tmo_idle", busy, 0);
    chk("tmo_no_valid", result_valid, 0);
    chk("tmo_result_kept", result, 6);
    se_delay = TO - 1;
    q.push_back(6);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("err_cleared", timeout_err, 0);
    wait_close();
    repeat (TO - 1) tick();
    chk("race_busy", busy, 1);
    tick();
    chk("race_capture", result_valid, 1);
    chk("race_no_err", timeout_err, 0);
    ack();
    se_delay = 1;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    chk("abort_at_idx2", cnt, 2);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_idle", busy, 0);
    chk("abort_en", cnt_en, 0);
    chk("abort_valid", result_valid, 0);
    repeat (10) tick();
    chk("abort_no_result", result_valid, 0);
    q.push_back(6);
    abort = 1'b1;
    start = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    chk("abort_start_clr", cnt_clr, 1);
    wait_valid();
    ack();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (2) tick();
    chk("pre_rst_stream", cnt_en, 1);
    rst = 1'b1;
    tick();
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_outs", {cnt_clr, cnt_en, data_start, result_valid, timeout_err}, 0);
    chk("mid_rst_result", result, 0);
    repeat (2) tick();
    rst = 1'b0;
    tick();
    chk("post_rst_busy", busy, 0);
    chk("queue_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
